sort_three_floats_stream: RTL and testbench
===========================================

# sort_three_floats_stream

Sequential, handshaked sorter for three floating-point values. It accepts three FLEN-bit floats one at a time over a valid/ready input channel, orders them ascending with a single time-shared `f_less_or_equal` instance, and streams them out one at a time over a valid/ready output channel. It is the serial-interface, FSM-based sorter for datapaths that cannot afford three comparators or wide parallel buses.

## Interface
- No module parameters. `FLEN` is the global width from `config-shared.vh` (normally 64).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `up_valid`  in  1  input word present.
- `up_data`  in  FLEN  input float.
- `up_ready`  out  1  block can accept an input word.
- `down_valid`  out  1  output word present.
- `down_data`  out  FLEN  sorted float (smallest first).
- `down_last`  out  1  marks the third word of a group.
- `down_err`  out  1  at least one comparison in this group reported `err`. Valid with every beat of the group.

## Operation
- **Comparator**
  - Exactly one `f_less_or_equal` instance.
  - Its operands come from a mux selected by the state.
  - Its `res`/`err` outputs are ignored outside the CMP states.
- **Storage:** three FLEN registers `buf[0..2]`, a 2-bit input count `cnt`, a 2-bit output index `idx`, and a sticky error flag `err_q`.
- **States:** LOAD, CMP01A, CMP12, CMP01B, EMIT.
- **LOAD**
  - `up_ready` = 1.
  - On `up_valid & up_ready`, write `buf[cnt]` = `up_data` and increment `cnt`.
  - On the third accept (`cnt` == 2): go to CMP01A and clear `cnt`.
- **CMP01A**
  - Compare `buf[0]` and `buf[1]`.
  - If `res` == 0 and `err` == 0, swap them.
  - `err_q` |= `err`.
  - Go to CMP12.
- **CMP12:** same rule on `buf[1]` and `buf[2]`, then go to CMP01B.
- **CMP01B:** same rule on `buf[0]` and `buf[1]`, then go to EMIT.
- **Swap rule**
  - A swap happens only on a strict greater-than, so equal values keep their arrival order (stable sort).
  - When `err` = 1 there is no swap and the order is left unchanged.
- **EMIT**
  - `down_valid` = 1, `down_data` = `buf[idx]`, `down_last` = (`idx` == 2), `down_err` = `err_q`.
  - On `down_valid & down_ready`, increment `idx`.
  - On the handshake with `idx` == 2: clear `idx` and `err_q`, and go to LOAD.
- **Outputs are combinational from state.**
  - `up_ready` = (state == LOAD).
  - `down_valid` = (state == EMIT).
  - `down_data`, `down_last` and `down_err` are 0 outside EMIT.
- **Outside LOAD:** `up_valid` is ignored; no words are accepted and no data is lost.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n` low)
  - state = LOAD, `cnt` = 0, `idx` = 0, `buf` = 0, `err_q` = 0.
  - Outputs: `up_ready` = 1, `down_valid` = 0, `down_data` = 0, `down_last` = 0, `down_err` = 0.
  - The environment must not assert `up_valid` while `rst_n` is low.
- **Latency**
  - The third input is accepted at edge E0. Compares happen at E1, E2 and E3.
  - `down_valid` is high in the cycle after E3.
  - The minimum group period is 3 in + 3 compare + 3 out = 9 cycles.
- **Backpressure**
  - While `down_valid` = 1 and `down_ready` = 0, `down_data`, `down_last` and `down_err` stay stable.
  - `down_ready` may be high before `down_valid`.
- **Input gaps:** `up_valid` may deassert between words; `cnt` holds.
- **Group boundary:** the cycle after the final output handshake, `up_ready` = 1. There is no overlap of input and output phases.
- **Reset mid-operation:** a partial group (LOAD with `cnt` > 0, any CMP state, or part-way through EMIT) is discarded. No stale word or stale `down_err` appears after reset.

## Test plan
- **Basic sort:** inputs 4008000000000000 (3.0), 3FF0000000000000 (1.0), 4000000000000000 (2.0) with `down_ready` = 1 → outputs 1.0, 2.0, 3.0.
  - `down_last` high only on 3.0; `down_err` = 0.
  - First `down_valid` exactly 4 cycles after the third accept.
- **Reverse order plus negatives:** inputs 4000000000000000 (2.0), 0000000000000000 (+0), BFF0000000000000 (-1.0) → outputs -1.0, +0, 2.0.
  - Then a second group back-to-back sorts correctly with `down_err` = 0.
- **Stability:** inputs 0000000000000000, 8000000000000000, 0000000000000000 (+0, -0, +0) → outputs in arrival order (+0, -0, +0).
- **NaN:** inputs 3FF0000000000000, 7FF8000000000000, 4000000000000000 → `down_err` = 1 on all three beats.
  - The next clean group shows `down_err` = 0.
- **Handshake stress**
  - Random `up_valid` gaps, plus `down_ready` low for 5 cycles on each beat.
  - Check data is held stable, there are no duplicates or drops, and `up_ready` = 0 throughout CMP and EMIT.
- **Reset mid-operation**
  - Assert `rst_n` low after 2 inputs, and again during EMIT at `idx` = 1.
  - Outputs go to reset values immediately; the next full group sorts correctly.

Source files
------------

// File: rtl/sort_three_floats_stream_if.sv
// ---------------------------------------------------------------------------
// sort_three_floats_stream_if
//
// Handshake bundle for the serial three-float sorter. It carries the input
// channel (one float per beat) and the output channel (sorted floats, one
// per beat, with a group-end marker and a group error flag).
//
//   up_valid   : input word present               (environment -> sorter)
//   up_data    : input float, FLEN bits           (environment -> sorter)
//   up_ready   : sorter can take an input word    (sorter -> environment)
//   down_valid : output word present              (sorter -> environment)
//   down_data  : sorted float, smallest first     (sorter -> environment)
//   down_last  : third word of the group          (sorter -> environment)
//   down_err   : a compare in this group saw err  (sorter -> environment)
//   down_ready : environment takes the output     (environment -> sorter)
//
// Modports:
//   slave  : the sorter's view
//   master : the environment's view (source of up_*, sink of down_*)
// ---------------------------------------------------------------------------
interface sort_three_floats_stream_if #(
  parameter int FLEN = 64
);
  logic            up_valid;
  logic [FLEN-1:0] up_data;
  logic            up_ready;
  logic            down_valid;
  logic [FLEN-1:0] down_data;
  logic            down_last;
  logic            down_err;
  logic            down_ready;

  modport slave (
    input  up_valid,
    input  up_data,
    input  down_ready,
    output up_ready,
    output down_valid,
    output down_data,
    output down_last,
    output down_err
  );

  modport master (
    output up_valid,
    output up_data,
    output down_ready,
    input  up_ready,
    input  down_valid,
    input  down_data,
    input  down_last,
    input  down_err
  );
endinterface

// File: rtl/sort_three_floats_stream.sv
// ---------------------------------------------------------------------------
// sort_three_floats_stream
//
// Serial, handshaked sorter for groups of three IEEE-754 floats. Words are
// collected one per handshake, ordered ascending by three compare-and-swap
// steps (0/1, 1/2, 0/1) on a single time-shared comparator, then streamed
// out smallest first. Equal values keep arrival order; a compare that
// reports err (NaN operand) never swaps and marks the whole group.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   io    : sort_three_floats_stream_if.slave
//           up_valid/up_data/up_ready                 input channel
//           down_valid/down_data/down_last/down_err/
//           down_ready                                output channel
//
// Also contains f_less_or_equal: combinational a <= b on FLEN-bit floats,
// res = 1 when a <= b, err = 1 (res = 0) when either operand is NaN.
// ---------------------------------------------------------------------------

module f_less_or_equal #(
  parameter int FLEN = 64
) (
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res,
  output logic            err
);
  // Exponent width of the supported IEEE binary formats.
  localparam int EXP_W = (FLEN == 16) ? 5 : ((FLEN == 32) ? 8 : 11);
  localparam int MAN_W = FLEN - 1 - EXP_W;

  logic            a_sign;
  logic            b_sign;
  logic [FLEN-2:0] a_mag;
  logic [FLEN-2:0] b_mag;
  logic            a_nan;
  logic            b_nan;

  assign a_sign = a[FLEN-1];
  assign b_sign = b[FLEN-1];
  assign a_mag  = a[FLEN-2:0];
  assign b_mag  = b[FLEN-2:0];
  assign a_nan  = (&a[FLEN-2 -: EXP_W]) && (|a[MAN_W-1:0]);
  assign b_nan  = (&b[FLEN-2 -: EXP_W]) && (|b[MAN_W-1:0]);

  // Sign-magnitude ordering: magnitudes compare as unsigned integers, the
  // sense flips for negatives, and +0 / -0 are equal.
  always_comb begin
    res = 1'b0;
    err = 1'b0;
    if (a_nan || b_nan) begin
      err = 1'b1;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      res = 1'b1;
    end else if (a_sign != b_sign) begin
      res = a_sign;
    end else if (!a_sign) begin
      res = (a_mag <= b_mag);
    end else begin
      res = (a_mag >= b_mag);
    end
  end
endmodule

module sort_three_floats_stream (
  input  logic                        clk,
  input  logic                        rst_n,
  sort_three_floats_stream_if.slave   io
);
  localparam int FLEN = 64;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CMP01A = 3'd1,
    CMP12  = 3'd2,
    CMP01B = 3'd3,
    EMIT   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [FLEN-1:0] buf0;
  logic [FLEN-1:0] buf1;
  logic [FLEN-1:0] buf2;
  logic [1:0]      cnt;
  logic [1:0]      idx;
  logic            err_q;

  logic            in_cmp;
  logic [FLEN-1:0] cmp_a;
  logic [FLEN-1:0] cmp_b;
  logic            cmp_res;
  logic            cmp_err;
  logic            swap;
  logic            up_fire;
  logic            down_fire;
  logic [FLEN-1:0] emit_word;

  // ---- shared comparator ---------------------------------------------------
  // Only CMP12 looks at the upper pair; both CMP01 passes and every non-CMP
  // state present the lower pair, whose result is then ignored.
  assign in_cmp = (state == CMP01A) || (state == CMP12) || (state == CMP01B);
  assign cmp_a  = (state == CMP12) ? buf1 : buf0;
  assign cmp_b  = (state == CMP12) ? buf2 : buf1;

  f_less_or_equal #(
    .FLEN (FLEN)
  ) u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .res (cmp_res),
    .err (cmp_err)
  );

  // Strict greater-than only: equal values stay put, and a NaN compare
  // leaves the order untouched.
  assign swap      = in_cmp && !cmp_res && !cmp_err;
  assign up_fire   = io.up_valid && io.up_ready;
  assign down_fire = io.down_valid && io.down_ready;

  // ---- FSM: state register -------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // ---- FSM: next state -----------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (up_fire && (cnt == 2'd2)) begin
          state_next = CMP01A;
        end
      end
      CMP01A: state_next = CMP12;
      CMP12:  state_next = CMP01B;
      CMP01B: state_next = EMIT;
      EMIT: begin
        if (down_fire && (idx == 2'd2)) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // ---- FSM: outputs --------------------------------------------------------
  always_comb begin
    case (idx)
      2'd0:    emit_word = buf0;
      2'd1:    emit_word = buf1;
      default: emit_word = buf2;
    endcase
  end

  always_comb begin
    io.up_ready   = 1'b0;
    io.down_valid = 1'b0;
    io.down_data  = '0;
    io.down_last  = 1'b0;
    io.down_err   = 1'b0;
    case (state)
      LOAD: begin
        io.up_ready = 1'b1;
      end
      EMIT: begin
        io.down_valid = 1'b1;
        io.down_data  = emit_word;
        io.down_last  = (idx == 2'd2);
        io.down_err   = err_q;
      end
      default: begin
      end
    endcase
  end

  // ---- datapath: capture, compare-and-swap, emit index ---------------------
  // Only one of up_fire / swap / down_fire can be active in a given state,
  // so the branches below never fight over a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0  <= '0;
      buf1  <= '0;
      buf2  <= '0;
      cnt   <= 2'd0;
      idx   <= 2'd0;
      err_q <= 1'b0;
    end else begin
      if (up_fire) begin
        case (cnt)
          2'd0:    buf0 <= io.up_data;
          2'd1:    buf1 <= io.up_data;
          default: buf2 <= io.up_data;
        endcase
        cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
      end

      if (swap) begin
        if (state == CMP12) begin
          buf1 <= buf2;
          buf2 <= buf1;
        end else begin
          buf0 <= buf1;
          buf1 <= buf0;
        end
      end

      if (in_cmp) begin
        err_q <= err_q | cmp_err;
      end

      if (down_fire) begin
        if (idx == 2'd2) begin
          idx   <= 2'd0;
          err_q <= 1'b0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sort_three_floats_stream.sv
module tb_sort_three_floats_stream;
  localparam int FLEN = 64;

  localparam logic [63:0] P3   = 64'h4008000000000000;
  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] PZ   = 64'h0000000000000000;
  localparam logic [63:0] NZ   = 64'h8000000000000000;
  localparam logic [63:0] N1   = 64'hBFF0000000000000;
  localparam logic [63:0] N2   = 64'hC000000000000000;
  localparam logic [63:0] N3   = 64'hC008000000000000;
  localparam logic [63:0] P5   = 64'h4014000000000000;
  localparam logic [63:0] NH   = 64'hBFE0000000000000;
  localparam logic [63:0] PH   = 64'h3FE0000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;
  localparam logic [63:0] NINF = 64'hFFF0000000000000;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  typedef struct packed {
    logic [2:0][63:0] in_w;
    logic [2:0][63:0] out_w;
    logic             err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sort_three_floats_stream_if #(.FLEN(FLEN)) bus ();

  sort_three_floats_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl[7];

  function automatic vec_t mk(input logic [63:0] a0, a1, a2, o0, o1, o2, input logic e);
    vec_t v;
    v.in_w[0]  = a0; v.in_w[1]  = a1; v.in_w[2]  = a2;
    v.out_w[0] = o0; v.out_w[1] = o1; v.out_w[2] = o2;
    v.err      = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_word(input logic [63:0] d, input int gap);
    bit ok = 0;
    int guard = 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus.up_valid = 1'b1;
    bus.up_data  = d;
    while (!ok && guard < 50) begin
      @(negedge clk);
      if (bus.up_ready) ok = 1;
      @(posedge clk); #1;
      guard++;
    end
    if (!ok) timeout("send_word");
    bus.up_valid = 1'b0;
    bus.up_data  = '0;
  endtask

  task automatic recv_word(input string name, input logic [63:0] exp_d, input logic exp_last,
                           input logic exp_err, input int stall);
    int guard = 0;
    logic keep;
    logic [63:0] held;
    keep = bus.down_ready;
    if (stall > 0) bus.down_ready = 1'b0;
    while (!bus.down_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.down_valid) begin
      timeout(name);
      bus.down_ready = keep;
      return;
    end
    held = bus.down_data;
    repeat (stall) begin
      @(posedge clk); #1;
      check({name, " hold_data"}, bus.down_data, held);
      check({name, " hold_valid"}, {63'd0, bus.down_valid}, 64'd1);
      check({name, " up_ready_in_emit"}, {63'd0, bus.up_ready}, 64'd0);
    end
    check({name, " data"}, bus.down_data, exp_d);
    check({name, " last"}, {63'd0, bus.down_last}, {63'd0, exp_last});
    check({name, " err"}, {63'd0, bus.down_err}, {63'd0, exp_err});
    check({name, " up_ready"}, {63'd0, bus.up_ready}, 64'd0);
    bus.down_ready = 1'b1;
    @(posedge clk); #1;
    bus.down_ready = keep;
  endtask

  task automatic run_group(input string name, input vec_t v, input int gap_max, input int stall);
    for (int i = 0; i < 3; i++)
      send_word(v.in_w[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    for (int i = 0; i < 3; i++)
      recv_word($sformatf("%s[%0d]", name, i), v.out_w[i], (i == 2), v.err, stall);
    check({name, " boundary up_ready"}, {63'd0, bus.up_ready}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " up_ready"},   {63'd0, bus.up_ready},   64'd1);
    check({name, " down_valid"}, {63'd0, bus.down_valid}, 64'd0);
    check({name, " down_data"},  bus.down_data,           64'd0);
    check({name, " down_last"},  {63'd0, bus.down_last},  64'd0);
    check({name, " down_err"},   {63'd0, bus.down_err},   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(P2, PZ, N1,     N1, PZ, P2,     1'b0);
    tbl[1] = mk(N2, P5, NH,     N2, NH, P5,     1'b0);
    tbl[2] = mk(PZ, NZ, PZ,     PZ, NZ, PZ,     1'b0);
    tbl[3] = mk(P1, QNAN, P2,   P1, QNAN, P2,   1'b1);
    tbl[4] = mk(P1, P2, P3,     P1, P2, P3,     1'b0);
    tbl[5] = mk(N1, N3, N2,     N3, N2, N1,     1'b0);
    tbl[6] = mk(PINF, NINF, PH, NINF, PH, PINF, 1'b0);

    rst_n          = 1'b0;
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.down_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic sort with latency check; down_ready high before down_valid.
    bus.down_ready = 1'b1;
    send_word(P3, 0);
    send_word(P1, 0);
    bus.up_valid = 1'b1;
    bus.up_data  = P2;
    @(negedge clk);
    check("lat third accept ready", {63'd0, bus.up_ready}, 64'd1);
    @(posedge clk); #1;
    bus.up_valid = 1'b0;
    check("lat E0 valid", {63'd0, bus.down_valid}, 64'd0);
    check("lat E0 up_ready", {63'd0, bus.up_ready}, 64'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("lat E%0d valid", k), {63'd0, bus.down_valid}, {63'd0, (k == 3)});
    end
    recv_word("basic[0]", P1, 1'b0, 1'b0, 0);
    recv_word("basic[1]", P2, 1'b0, 1'b0, 0);
    recv_word("basic[2]", P3, 1'b1, 1'b0, 0);
    check("basic boundary up_ready", {63'd0, bus.up_ready}, 64'd1);
    bus.down_ready = 1'b0;

    // Table: back-to-back groups without gaps or stalls.
    for (int t = 0; t < 7; t++) run_group($sformatf("vec%0d", t), tbl[t], 0, 0);

    // Handshake stress: random input gaps, 5-cycle stall on every beat.
    for (int t = 0; t < 7; t++) run_group($sformatf("stress%0d", t), tbl[t], 3, 5);

    // Reset after two inputs: partial group discarded.
    send_word(P5, 0);
    send_word(N1, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_load");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_group("after_rst_load", tbl[0], 0, 0);

    // Reset during EMIT at idx 1 of an error group: no stale err afterwards.
    for (int i = 0; i < 3; i++) send_word(tbl[3].in_w[i], 0);
    recv_word("pre_rst_emit[0]", P1, 1'b0, 1'b1, 0);
    check("pre_rst_emit valid", {63'd0, bus.down_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_emit");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_group("after_rst_emit", tbl[5], 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
